// File: rtl/fsm_counter_launcher_pkg.sv
// Shared definitions for the counter-engine launcher: state encoding and the
// default count width, which must match the engine's num_cnt port.
package fsm_counter_launcher_pkg;

  // Default width of the count value handed to the engine.
  localparam int unsigned CNT_W_DEF = 7;

  // Launcher control states.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

endpackage

// File: rtl/fsm_counter_launcher_fifo.sv
// Synchronous job FIFO for the launcher (DEPTH x WIDTH, DEPTH a power of 2).
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   push, wr_data write request; ignored while full
//   pop           read request; ignored while empty
//   head          oldest entry (valid when !empty)
//   count         occupancy, registered
//   ready         registered !full
//   empty         registered empty flag
module fsm_counter_launcher_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ready,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_nxt;

  assign do_push   = push && ready;
  assign do_pop    = pop && !empty;
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);
  assign head      = mem[rd_ptr];

  // Storage array needs no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b1;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt != CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/fsm_counter_launcher.sv
// Launcher for one counter engine: queues count jobs from a valid/ready port
// and launches them one at a time with a single-cycle o_run pulse, waiting for
// i_done before the job is counted complete. Zero-count jobs complete without
// touching the engine.
// Optional watchdog: define FSM_LAUNCH_TIMEOUT_EN to drop a job that sits in
// WAIT_DONE for TIMEOUT_CYC cycles (o_timeout pulses); otherwise o_timeout=0.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_req_valid         job request valid
//   i_req_num_cnt       job count value
//   o_req_ready         job FIFO not full
//   o_run               one-cycle launch pulse
//   o_num_cnt           count to engine, held from LAUNCH through WAIT_DONE
//   i_idle              engine idle
//   i_done              engine done, honoured only in WAIT_DONE
//   o_busy              launcher active or jobs queued
//   o_job_done          one-cycle pulse per completed job
//   o_jobs_done         wrapping completed-job counter
//   o_timeout           one-cycle watchdog expiry pulse
module fsm_counter_launcher
  import fsm_counter_launcher_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned JOBS_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic [CNT_W-1:0]  i_req_num_cnt,
  output logic              o_req_ready,
  output logic              o_run,
  output logic [CNT_W-1:0]  o_num_cnt,
  input  logic              i_idle,
  input  logic              i_done,
  output logic              o_busy,
  output logic              o_job_done,
  output logic [JOBS_W-1:0] o_jobs_done,
  output logic              o_timeout
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_e             state;
  state_e             state_nxt;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   head;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic               fifo_ready;
  logic               fifo_empty;
  logic               run_q;
  logic [CNT_W-1:0]   num_cnt_q;
  logic               job_done_q;
  logic [JOBS_W-1:0]  jobs_done_q;
  logic               busy_q;
  logic               expire;

`ifdef FSM_LAUNCH_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
`endif

  assign push = i_req_valid && fifo_ready;

  fsm_counter_launcher_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH)
  ) u_launcher_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (i_req_num_cnt),
    .head    (head),
    .count   (count),
    .ready   (fifo_ready),
    .empty   (fifo_empty)
  );

  // Mirror of the FIFO occupancy update so o_busy can be registered.
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Next-state and FIFO pop decode.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    expire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head == '0) begin
            pop       = 1'b1;
            state_nxt = ST_DONE;
          end else if (i_idle) begin
            state_nxt = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        pop       = 1'b1;
        state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_done) begin
          state_nxt = ST_DONE;
`ifdef FSM_LAUNCH_TIMEOUT_EN
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
          expire    = 1'b1;
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      run_q       <= 1'b0;
      num_cnt_q   <= '0;
      job_done_q  <= 1'b0;
      jobs_done_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_q      <= (state_nxt == ST_LAUNCH);
      job_done_q <= (state_nxt == ST_DONE);
      busy_q     <= (state_nxt != ST_IDLE) || (count_nxt != '0);
      // Capture only on a real launch; zero-count jobs leave o_num_cnt alone.
      if (state_nxt == ST_LAUNCH) begin
        num_cnt_q <= head;
      end
      if (state_nxt == ST_DONE) begin
        jobs_done_q <= jobs_done_q + JOBS_W'(1);
      end
    end
  end

`ifdef FSM_LAUNCH_TIMEOUT_EN
  // Watchdog: counts WAIT_DONE cycles, restarting on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state != ST_WAIT_DONE) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  // No watchdog hardware; the parameter only folds into a constant zero.
  assign o_timeout = expire && (TIMEOUT_CYC != 0);
`endif

  assign o_req_ready = fifo_ready;
  assign o_run       = run_q;
  assign o_num_cnt   = num_cnt_q;
  assign o_busy      = busy_q;
  assign o_job_done  = job_done_q;
  assign o_jobs_done = jobs_done_q;

endmodule

// File: tb/tb_fsm_counter_launcher.sv
// Directed bench for fsm_counter_launcher: reset values, single launch, full
// FIFO ordering, zero-count jobs, held-off engine, reset mid-job and (with
// FSM_LAUNCH_TIMEOUT_EN) the watchdog.
module tb_fsm_counter_launcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [6:0]  req_num_cnt;
  logic        req_ready;
  logic        run;
  logic [6:0]  num_cnt;
  logic        idle;
  logic        done;
  logic        busy;
  logic        job_done;
  logic [15:0] jobs_done;
  logic        timeout;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fsm_counter_launcher #(
    .CNT_W       (7),
    .DEPTH       (4),
    .JOBS_W      (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_req_valid   (req_valid),
    .i_req_num_cnt (req_num_cnt),
    .o_req_ready   (req_ready),
    .o_run         (run),
    .o_num_cnt     (num_cnt),
    .i_idle        (idle),
    .i_done        (done),
    .o_busy        (busy),
    .o_job_done    (job_done),
    .o_jobs_done   (jobs_done),
    .o_timeout     (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a launch, check it, then complete it via i_done.
  task automatic run_job(input logic [31:0] exp_num, input string tag);
    for (int i = 0; i < 12 && run !== 1'b1; i++) tick();
    chk({tag, "_run"}, 32'(run), 1);
    chk({tag, "_num"}, 32'(num_cnt), exp_num);
    tick();
    chk({tag, "_run_pulse"}, 32'(run), 0);
    chk({tag, "_num_hold"}, 32'(num_cnt), exp_num);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk({tag, "_job_done"}, 32'(job_done), 1);
    tick();
    chk({tag, "_job_done_pulse"}, 32'(job_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_num_cnt = '0;
    idle        = 1'b1;
    done        = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_run", 32'(run), 0);
    chk("rst_num", 32'(num_cnt), 0);
    chk("rst_jobs", 32'(jobs_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_job_done", 32'(job_done), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // 1: single job, o_run two edges after the accepting cycle
    req_valid   = 1'b1;
    req_num_cnt = 7'd100;
    tick();
    req_valid = 1'b0;
    chk("t1_run_early", 32'(run), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_run", 32'(run), 1);
    chk("t1_num", 32'(num_cnt), 100);
    tick();
    chk("t1_run_pulse", 32'(run), 0);
    chk("t1_num_hold", 32'(num_cnt), 100);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t1_job_done", 32'(job_done), 1);
    chk("t1_jobs", 32'(jobs_done), 1);
    tick();
    chk("t1_job_done_pulse", 32'(job_done), 0);
    chk("t1_busy_end", 32'(busy), 0);

    // 2: fill FIFO with engine held off, then drain in order
    idle = 1'b0;
    for (int v = 5; v <= 8; v++) begin
      req_valid   = 1'b1;
      req_num_cnt = 7'(v);
      tick();
    end
    chk("t2_full_ready", 32'(req_ready), 0);
    req_num_cnt = 7'd9;
    tick();
    req_valid = 1'b0;
    chk("t2_full_hold", 32'(req_ready), 0);
    idle = 1'b1;
    run_job(5, "t2_j5");
    chk("t2_ready_after_pop", 32'(req_ready), 1);
    run_job(6, "t2_j6");
    run_job(7, "t2_j7");
    run_job(8, "t2_j8");
    chk("t2_jobs", 32'(jobs_done), 5);
    chk("t2_busy_end", 32'(busy), 0);

    // 3: zero-count job completes without a launch; stray i_done ignored
    req_valid   = 1'b1;
    req_num_cnt = 7'd0;
    tick();
    req_valid = 1'b0;
    chk("t3_run0", 32'(run), 0);
    tick();
    chk("t3_run1", 32'(run), 0);
    chk("t3_job_done", 32'(job_done), 1);
    chk("t3_jobs", 32'(jobs_done), 6);
    chk("t3_num_unchanged", 32'(num_cnt), 8);
    tick();
    chk("t3_job_done_pulse", 32'(job_done), 0);
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    chk("t3_stray_done", 32'(job_done), 0);
    chk("t3_stray_jobs", 32'(jobs_done), 6);

    // 4: engine busy holds a queued job in IDLE
    idle        = 1'b0;
    req_valid   = 1'b1;
    req_num_cnt = 7'd33;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_no_run", 32'(run), 0);
    chk("t4_busy", 32'(busy), 1);
    idle = 1'b1;
    tick();
    chk("t4_run", 32'(run), 1);
    chk("t4_num", 32'(num_cnt), 33);
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t4_job_done", 32'(job_done), 1);
    chk("t4_jobs", 32'(jobs_done), 7);
    tick();

    // 5: reset during WAIT_DONE with two jobs queued
    req_valid = 1'b1;
    for (int v = 11; v <= 13; v++) begin
      req_num_cnt = 7'(v);
      tick();
    end
    req_valid = 1'b0;
    tick();
    chk("t5_busy_pre", 32'(busy), 1);
    chk("t5_num_pre", 32'(num_cnt), 11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ready", 32'(req_ready), 1);
    chk("t5_jobs", 32'(jobs_done), 0);
    chk("t5_num", 32'(num_cnt), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t5_job_done_a", 32'(job_done), 0);
    tick();
    chk("t5_job_done_b", 32'(job_done), 0);
    chk("t5_run", 32'(run), 0);
    chk("t5_busy_post", 32'(busy), 0);

`ifdef FSM_LAUNCH_TIMEOUT_EN
    // 6: watchdog drops a job that never completes
    req_valid   = 1'b1;
    req_num_cnt = 7'd21;
    tick();
    req_valid = 1'b0;
    tick();
    chk("t6_run", 32'(run), 1);
    tick();
    repeat (15) tick();
    chk("t6_no_timeout_yet", 32'(timeout), 0);
    tick();
    chk("t6_timeout", 32'(timeout), 1);
    chk("t6_no_job_done", 32'(job_done), 0);
    chk("t6_jobs", 32'(jobs_done), 0);
    tick();
    chk("t6_timeout_pulse", 32'(timeout), 0);
    req_valid   = 1'b1;
    req_num_cnt = 7'd22;
    tick();
    req_valid = 1'b0;
    run_job(22, "t6_next");
    chk("t6_jobs_after", 32'(jobs_done), 1);
`else
    chk("t6_timeout_off", 32'(timeout), 0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
